// File: rtl/sparserdes_packer.sv
// sparserdes_packer: frame controller above the root of the sparse serializer
// tree. It requests a frame from the root and captures the serialized bits.
// The bits are packed LSB-first into WORD_W-bit words and queued in a small
// FIFO. The FIFO drains on a valid/ready stream that carries a last marker and
// a count of valid bits.
//
// Handshake: a word moves on a rising clk edge exactly when out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_data/out_nbits/out_last hold steady. out_valid never depends on
// out_ready.
module sparserdes_packer #(
    parameter int WORD_W         = 8,
    parameter int MAX_FRAME_BITS = 62,
    parameter int DEPTH          = 8,
    parameter int LAT            = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    input  logic                          tree_nonempty,
    output logic                          tree_read,
    input  logic                          tree_bit,
    input  logic                          tree_done,
    output logic [WORD_W-1:0]             out_data,
    output logic [$clog2(WORD_W+1)-1:0]   out_nbits,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic                          frame_done,
    output logic [1:0]                    dbg_state
);

    localparam int NB_W  = $clog2(WORD_W + 1);
    localparam int BIT_W = $clog2(WORD_W);
    localparam int TOT_W = $clog2(MAX_FRAME_BITS + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LAT_W = $clog2(LAT + 2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_REFRACT = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Capture datapath.
    logic [WORD_W-1:0] shreg;
    logic [BIT_W-1:0]  bitcnt;
    logic [TOT_W-1:0]  total_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    // The last full word is held here until a further captured bit (or the
    // end of the frame) tells us whether it carries the last marker.
    logic [WORD_W-1:0] pend_data;
    logic              pend_valid;

    // FIFO storage and bookkeeping.
    logic [WORD_W-1:0] mem_data  [DEPTH];
    logic [NB_W-1:0]   mem_nbits [DEPTH];
    logic              mem_last  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    // Decoded control.
    logic              fifo_empty, fifo_full;
    logic              start_frame, start_empty;
    logic              capture_win, room, bit_take, bit_drop, word_full;
    logic [WORD_W-1:0] bit_mask, new_word;
    logic              push, pop;
    logic [WORD_W-1:0] push_data;
    logic [NB_W-1:0]   push_nbits;
    logic              push_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == CNT_W'(DEPTH));
    assign start_frame = (state == ST_IDLE) && start && fifo_empty && tree_nonempty;
    assign start_empty = (state == ST_IDLE) && start && fifo_empty && !tree_nonempty;

    // The root's bits are valid LAT cycles after tree_read rose; lat_cnt
    // saturates at LAT and opens the capture window from then on.
    assign capture_win = (state == ST_REQ) && (lat_cnt == LAT_W'(LAT));
    assign room        = (total_cnt < TOT_W'(MAX_FRAME_BITS));
    assign bit_take    = capture_win && room;
    assign bit_drop    = capture_win && !room;
    assign word_full   = bit_take && (bitcnt == BIT_W'(WORD_W - 1));
    assign bit_mask    = WORD_W'(1) << bitcnt;
    assign new_word    = tree_bit ? (shreg | bit_mask) : shreg;

    assign busy      = (state != ST_IDLE);
    assign tree_read = (state == ST_REQ);
    assign dbg_state = state;

    assign pop       = out_valid && out_ready;
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? mem_data[rd_ptr]  : '0;
    assign out_nbits = out_valid ? mem_nbits[rd_ptr] : '0;
    assign out_last  = out_valid ? mem_last[rd_ptr]  : 1'b0;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start_frame) state_nxt = ST_REQ;
            ST_REQ:     if (capture_win && tree_done) state_nxt = ST_FLUSH;
            ST_FLUSH:   state_nxt = ST_REFRACT;
            ST_REFRACT: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Select the single word (if any) written into the FIFO this cycle.
    always_comb begin
        push       = 1'b0;
        push_data  = '0;
        push_nbits = '0;
        push_last  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_empty) begin
                    push      = 1'b1;
                    push_last = 1'b1;
                end
            end
            ST_REQ: begin
                // A fresh captured bit proves the held word is not the last.
                if (bit_take && pend_valid) begin
                    push       = 1'b1;
                    push_data  = pend_data;
                    push_nbits = NB_W'(WORD_W);
                end
            end
            ST_FLUSH: begin
                if (bitcnt != '0) begin
                    push       = 1'b1;
                    push_data  = shreg;
                    push_nbits = NB_W'(bitcnt);
                    push_last  = 1'b1;
                end else if (pend_valid) begin
                    push       = 1'b1;
                    push_data  = pend_data;
                    push_nbits = NB_W'(WORD_W);
                    push_last  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Capture datapath: bit packing, bit counters, held word, sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= '0;
            bitcnt     <= '0;
            total_cnt  <= '0;
            lat_cnt    <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= push && push_last;
            case (state)
                ST_IDLE: begin
                    lat_cnt <= '0;
                    if (start_frame) begin
                        overflow   <= 1'b0;
                        shreg      <= '0;
                        bitcnt     <= '0;
                        total_cnt  <= '0;
                        pend_valid <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (lat_cnt != LAT_W'(LAT)) begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                    if (bit_take) begin
                        total_cnt  <= total_cnt + 1'b1;
                        pend_valid <= 1'b0;
                        if (word_full) begin
                            pend_data  <= new_word;
                            pend_valid <= 1'b1;
                            shreg      <= '0;
                            bitcnt     <= '0;
                        end else begin
                            shreg  <= new_word;
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                    if (bit_drop) begin
                        overflow <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    pend_valid <= 1'b0;
                    shreg      <= '0;
                    bitcnt     <= '0;
                end
                default: ;
            endcase
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are only visible through the gated outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]  <= push_data;
            mem_nbits[wr_ptr] <= push_nbits;
            mem_last[wr_ptr]  <= push_last;
        end
    end

    // A frame only starts on an empty FIFO, so a push into a full one
    // means the frame sizing parameters are inconsistent.
    a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule

// File: tb/tb_sparserdes_packer.sv
// Bench for sparserdes_packer: behavioural root-node model, table of frames,
// randomized frames, and hand sequences for stall, reset and back-to-back.
module tb_sparserdes_packer;

  localparam int WORD_W = 8;
  localparam int MAXB   = 62;
  localparam int DEPTH  = 8;
  localparam int LAT    = 1;
  localparam int NB_W   = $clog2(WORD_W + 1);
  localparam int EW     = WORD_W + NB_W + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              tree_nonempty = 1'b0;
  logic              tree_bit = 1'b0;
  logic              tree_done = 1'b0;
  logic              out_ready = 1'b0;
  logic              busy, tree_read, out_last, out_valid, overflow, frame_done;
  logic [WORD_W-1:0] out_data;
  logic [NB_W-1:0]   out_nbits;
  logic [1:0]        dbg_state;

  sparserdes_packer #(.WORD_W(WORD_W), .MAX_FRAME_BITS(MAXB), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .tree_nonempty(tree_nonempty), .tree_read(tree_read), .tree_bit(tree_bit),
    .tree_done(tree_done), .out_data(out_data), .out_nbits(out_nbits),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- root node model ----------------
  // Presents frame_bits[0..frame_len-1] one per cycle, LAT cycles after
  // tree_read rose, with tree_done on the final bit.
  logic [127:0] frame_bits = '0;
  int           frame_len = 0;
  int           tree_idx = 0;
  int           rd_age = 0;

  always @(posedge clk) begin
    #2;
    if (tree_read) begin
      if (rd_age >= LAT && tree_idx < frame_len) begin
        tree_bit  = frame_bits[tree_idx];
        tree_done = (tree_idx == frame_len - 1);
        tree_idx++;
      end else begin
        tree_bit  = 1'b0;
        tree_done = 1'b0;
      end
      rd_age++;
    end else begin
      rd_age    = 0;
      tree_idx  = 0;
      tree_bit  = 1'b0;
      tree_done = 1'b0;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_pct = 100;
  int fd_total = 0;
  int words_total = 0;
  int rise_total = 0;
  int done_cyc = -100;
  int last_nb_seen = -1;
  logic prev_tr = 1'b0;
  logic done_seen = 1'b0;
  logic prev_stall = 1'b0;
  logic [EW-1:0] held = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Observes the DUT with the inputs that will be sampled at the next edge.
  task automatic mon();
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    got = {out_data, out_nbits, out_last};
    if (frame_done) fd_total++;
    if (done_seen) chk("tree_read_fall", 32'(tree_read), 0);
    if (tree_read && !prev_tr) begin
      rise_total++;
      n_tests++;
      if (cyc - done_cyc < 3) begin
        n_fail++;
        $display("FAIL refract_gap: got %0d cycles after done, required >= 3", cyc - done_cyc);
      end
    end
    done_seen = tree_done && tree_read;
    if (done_seen) done_cyc = cyc;
    if (prev_stall && out_valid) chk("stall_stable", 32'(got), 32'(held));
    if (out_valid && out_ready) begin
      n_tests++;
      words_total++;
      if (out_last) last_nb_seen = int'(out_nbits);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL word: got data=%0h nbits=%0d last=%0b expected data=%0h nbits=%0d last=%0b",
                   out_data, out_nbits, out_last, e[EW-1 -: WORD_W], e[NB_W:1], e[0]);
        end
      end
    end
    prev_stall = out_valid && !out_ready;
    held = got;
    prev_tr = tree_read;
  endtask

  // One clock: choose out_ready, observe, advance to the next falling edge.
  task automatic tick();
    out_ready = (int'($urandom_range(99)) < ready_pct);
    mon();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Reference: the words a frame must produce, from the packing rules.
  task automatic model_frame(input int len, input logic [127:0] bits, input logic ne);
    int eff, nw, nb;
    logic [WORD_W-1:0] d;
    logic [NB_W-1:0] nbv;
    logic lst;
    if (!ne) begin
      exp_q.push_back('0 | EW'(1));
    end else begin
      eff = (len > MAXB) ? MAXB : len;
      nw = (eff + WORD_W - 1) / WORD_W;
      for (int w = 0; w < nw; w++) begin
        nb = eff - w * WORD_W;
        if (nb > WORD_W) nb = WORD_W;
        d = '0;
        for (int b = 0; b < nb; b++) d[b] = bits[w * WORD_W + b];
        nbv = NB_W'(nb);
        lst = (w == nw - 1);
        exp_q.push_back({d, nbv, lst});
      end
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((busy || out_valid || exp_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    n_tests++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: got busy=%0b valid=%0b pending=%0d after %0d cycles, required idle",
               name, busy, out_valid, exp_q.size(), k);
    end
  endtask

  task automatic run_frame(input string name, input int len, input logic [127:0] bits,
                           input logic ne, input int exp_words, input int exp_lastnb,
                           input logic exp_ovf, input int pct);
    int fd0, w0;
    ready_pct = pct;
    wait_idle({name, "_pre"}, 400);
    fd0 = fd_total;
    w0 = words_total;
    last_nb_seen = -1;
    frame_bits = bits;
    frame_len = len;
    tree_nonempty = ne;
    model_frame(len, bits, ne);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(name, 400);
    tick();
    chk({name, "_words"}, 32'(words_total - w0), 32'(exp_words));
    chk({name, "_frame_done"}, 32'(fd_total - fd0), 1);
    chk({name, "_last_nbits"}, 32'(last_nb_seen), 32'(exp_lastnb));
    chk({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  typedef struct {
    int           len;
    logic [127:0] bits;
    logic         ne;
    int           words;
    int           lastnb;
    logic         ovf;
  } vec_t;

  localparam logic [127:0] C1 = 128'h0123_4567_89AB_CDEF_F0E1_D2C3_B4A5_9687;

  initial begin
    vec_t vecs[11];
    int fd0, w0, r0, k, len, eff;
    logic ne, cur_ovf;
    logic [127:0] bits;

    vecs[0]  = '{10, 128'h1CD,    1'b1, 2, 2, 1'b0};
    vecs[1]  = '{0,  128'h0,      1'b0, 1, 0, 1'b0};
    vecs[2]  = '{8,  128'hA5,     1'b1, 1, 8, 1'b0};
    vecs[3]  = '{1,  128'h1,      1'b1, 1, 1, 1'b0};
    vecs[4]  = '{62, C1,          1'b1, 8, 6, 1'b0};
    vecs[5]  = '{63, C1,          1'b1, 8, 6, 1'b1};
    vecs[6]  = '{70, C1,          1'b1, 8, 6, 1'b1};
    vecs[7]  = '{0,  128'h0,      1'b0, 1, 0, 1'b1};
    vecs[8]  = '{16, 128'hBEEF,   1'b1, 2, 8, 1'b0};
    vecs[9]  = '{64, ~C1,         1'b1, 8, 6, 1'b1};
    vecs[10] = '{24, 128'h123456, 1'b1, 3, 8, 1'b0};

    // ---- reset ----
    reset = 1'b1;
    ready_pct = 100;
    @(negedge clk);
    repeat (3) tick();
    chk("rst_tree_read", 32'(tree_read), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_word", 32'({out_data, out_nbits, out_last}), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    reset = 1'b0;
    tick();

    // ---- table of frames ----
    for (int i = 0; i < 11; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].len, vecs[i].bits, vecs[i].ne,
                vecs[i].words, vecs[i].lastnb, vecs[i].ovf, 100);
    end
    cur_ovf = 1'b0;

    // ---- stall: 16-bit frame held for 20 cycles, start ignored meanwhile ----
    ready_pct = 0;
    fd0 = fd_total;
    w0 = words_total;
    frame_bits = 128'hC3A5;
    frame_len = 16;
    tree_nonempty = 1'b1;
    model_frame(16, 128'hC3A5, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (busy && k < 100) begin tick(); k++; end
    chk("stall_frame_end", 32'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("stall_start_ignored_busy", 32'(busy), 0);
    chk("stall_start_ignored_read", 32'(tree_read), 0);
    repeat (18) tick();
    chk("stall_holding", 32'(out_valid), 1);
    chk("stall_no_pops", 32'(words_total - w0), 0);
    ready_pct = 100;
    wait_idle("stall", 100);
    tick();
    chk("stall_words", 32'(words_total - w0), 2);
    chk("stall_frame_done", 32'(fd_total - fd0), 1);

    // ---- back-to-back frames with start held ----
    fd0 = fd_total;
    w0 = words_total;
    r0 = rise_total;
    frame_bits = 128'h1CD;
    frame_len = 10;
    model_frame(10, 128'h1CD, 1'b1);
    model_frame(10, 128'h1CD, 1'b1);
    start = 1'b1;
    k = 0;
    while (rise_total - r0 < 2 && k < 300) begin tick(); k++; end
    start = 1'b0;
    chk("b2b_second_start", 32'(rise_total - r0), 2);
    wait_idle("b2b", 200);
    tick();
    chk("b2b_words", 32'(words_total - w0), 4);
    chk("b2b_frame_done", 32'(fd_total - fd0), 2);

    // ---- randomized frames with random backpressure ----
    for (int i = 0; i < 14; i++) begin
      len = $urandom_range(70, 1);
      bits = {$urandom, $urandom, $urandom, $urandom};
      ne = ($urandom_range(7) != 0);
      eff = (len > MAXB) ? MAXB : len;
      if (ne) cur_ovf = (len > MAXB);
      run_frame($sformatf("rnd%0d", i), len, bits, ne,
                ne ? (eff + WORD_W - 1) / WORD_W : 1,
                ne ? ((eff % WORD_W == 0) ? WORD_W : eff % WORD_W) : 0,
                cur_ovf, 60);
    end

    // ---- reset mid-frame after 5 captured bits ----
    ready_pct = 100;
    wait_idle("rst_pre", 200);
    fd0 = fd_total;
    w0 = words_total;
    frame_bits = {$urandom, $urandom, $urandom, $urandom};
    frame_len = 20;
    tree_nonempty = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!tree_read && k < 10) begin tick(); k++; end
    chk("mid_rst_read_up", 32'(tree_read), 1);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_tree_read", 32'(tree_read), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    reset = 1'b0;
    repeat (10) tick();
    chk("mid_rst_no_words", 32'(words_total - w0), 0);
    chk("mid_rst_no_done", 32'(fd_total - fd0), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);

    // ---- one normal frame after the abandoned one ----
    run_frame("post_rst", 10, 128'h1CD, 1'b1, 2, 2, 1'b0, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
